// File: rtl/jk_cnt_pkg.sv
// rtl/jk_cnt_pkg.sv - JK cell command encoding, default sizes and command helper.
package jk_cnt_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_cmd_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 10;

  // Cheapest command moving one cell from cur_bit to next_bit.
  function automatic jk_cmd_t jk_cmd_for(input logic cur_bit, input logic next_bit);
    if (cur_bit == next_bit) return HOLD;
    return next_bit ? SET : CLR;
  endfunction

endpackage

// File: rtl/jk_mod_counter_cell.sv
// rtl/jk_mod_counter_cell.sv - single JK storage bit (module jk_cell).
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter driving a row of JK cells.
// Optional JK_CNT_SATURATE_EN: hold at the terminal count instead of wrapping.
module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  jk_cmd_t          cmd [WIDTH];
  logic [WIDTH-1:0] din_clamped;
  logic             at_top;
  logic             at_bottom;
  logic             wrap_next;
  logic             ripple;

  assign din_clamped = (32'(din) >= 32'(MODULUS)) ? MAX_CNT : din;
  // Out-of-range states count as terminal so an up-count always recovers to 0.
  assign at_top      = 32'(q) >= 32'(MODULUS - 1);
  assign at_bottom   = (q == '0);
  assign tc          = en & (up ? (q == MAX_CNT) : at_bottom);

  always_comb begin
    wrap_next = 1'b0;
    ripple    = 1'b1;
    for (int i = 0; i < WIDTH; i++) cmd[i] = HOLD;

    if (load) begin
      for (int i = 0; i < WIDTH; i++) cmd[i] = din_clamped[i] ? SET : CLR;
    end else if (en && up && at_top) begin
      wrap_next = 1'b1;
`ifdef JK_CNT_SATURATE_EN
      // cells keep their HOLD default so the count sticks
`else
      for (int i = 0; i < WIDTH; i++) cmd[i] = q[i] ? CLR : HOLD;
`endif
    end else if (en && up) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd[i] = ripple ? TGL : HOLD;
        ripple = ripple & q[i];
      end
    end else if (en && at_bottom) begin
      wrap_next = 1'b1;
`ifdef JK_CNT_SATURATE_EN
      // cells keep their HOLD default so the count sticks
`else
      for (int i = 0; i < WIDTH; i++) cmd[i] = jk_cmd_for(q[i], MAX_CNT[i]);
`endif
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd[i] = ripple ? TGL : HOLD;
        ripple = ripple & ~q[i];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (cmd[g][1]),
      .k     (cmd[g][0]),
      .q     (q[g]),
      .q_bar (q_bar[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) wrap <= 1'b0;
    else        wrap <= wrap_next;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - directed vector bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] din;
  logic [3:0] q, q_bar;
  logic       tc, wrap;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] din;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
    .load  (load),
    .din   (din),
    .q     (q),
    .q_bar (q_bar),
    .tc    (tc),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic e, input logic u, input logic l,
                              input logic [3:0] d, input logic t, input logic [3:0] eq,
                              input logic w);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.din = d;
    v.exp_tc = t; v.exp_q = eq; v.exp_wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] d);
    @(negedge clk);
    reset = r; en = e; up = u; load = l; din = d;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;

    // rst en up ld din | tc-before-edge | q, wrap after edge
    add(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      add(1, 1, 1, 0, 0, (i % 10) == 9, 4'((i + 1) % 10), (i % 10) == 9);
    add(1, 0, 1, 1, 7, 0, 7, 0);
    add(1, 1, 0, 0, 0, 0, 6, 0);
    add(1, 1, 0, 0, 0, 0, 5, 0);
    add(1, 1, 0, 0, 0, 0, 4, 0);
    add(1, 1, 0, 0, 0, 0, 3, 0);
    add(1, 1, 0, 0, 0, 0, 2, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 9, 1);
    add(1, 1, 0, 0, 0, 0, 8, 0);
    add(1, 0, 0, 1, 13, 0, 9, 0);
    add(1, 1, 1, 1, 3, 1, 3, 0);
    add(1, 1, 1, 0, 0, 0, 4, 0);
    add(1, 1, 1, 0, 0, 0, 5, 0);
    add(1, 1, 1, 0, 0, 0, 6, 0);
    add(0, 1, 1, 1, 5, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 2, 0);
    add(1, 1, 1, 0, 0, 0, 3, 0);
    add(1, 1, 1, 0, 0, 0, 4, 0);
    add(1, 1, 1, 0, 0, 0, 5, 0);
    add(1, 0, 1, 0, 0, 0, 5, 0);
    add(1, 1, 1, 0, 0, 0, 6, 0);
    add(1, 1, 0, 0, 0, 0, 5, 0);
    add(1, 1, 0, 0, 0, 0, 4, 0);
    add(1, 0, 1, 1, 8, 0, 8, 0);
`ifdef JK_CNT_SATURATE_EN
    add(1, 1, 1, 0, 0, 0, 9, 0);
    add(1, 1, 1, 0, 0, 1, 9, 1);
    add(1, 1, 1, 0, 0, 1, 9, 1);
    add(1, 1, 1, 0, 0, 1, 9, 1);
`else
    add(1, 1, 1, 0, 0, 0, 9, 0);
    add(1, 1, 1, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 2, 0);
`endif

    foreach (vecs[n]) begin
      apply(vecs[n].rst, vecs[n].en, vecs[n].up, vecs[n].ld, vecs[n].din);
      #1;
      check($sformatf("tc[%0d]", n), {3'b0, tc}, {3'b0, vecs[n].exp_tc});
      @(posedge clk);
      #1;
      check($sformatf("q[%0d]", n), q, vecs[n].exp_q);
      check($sformatf("q_bar[%0d]", n), q_bar, ~vecs[n].exp_q);
      check($sformatf("wrap[%0d]", n), {3'b0, wrap}, {3'b0, vecs[n].exp_wrap});
    end

    // Reset taken right at the wrap point: wrap must stay low while reset holds.
    apply(1, 0, 1, 1, 9);
    apply(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_q", q, 4'd0);
      check("rst_hold_wrap", {3'b0, wrap}, 4'd0);
    end

    // Down-count terminal from 0 after a reset release.
    apply(1, 1, 0, 0, 0);
    #1;
    check("down_tc_at_0", {3'b0, tc}, 4'd1);
    @(posedge clk);
    #1;
`ifdef JK_CNT_SATURATE_EN
    check("down_sat_q", q, 4'd0);
`else
    check("down_wrap_q", q, 4'd9);
`endif
    check("down_wrap_pulse", {3'b0, wrap}, 4'd1);
    apply(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("wrap_clears", {3'b0, wrap}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built from a row of JK storage cells.
- Per-bit excitation logic computes each cell's J/K command from the current count, so the block consumes the cells' q outputs and produces their j/k inputs.
- It is the next stage after the JK flip-flop block in the sequential-logic set.
- It drives terminal-count and wrap flags for cascading into a wider counter.

Parameters:
- WIDTH, 4, number of JK cells (count bits).
- MODULUS, 10, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count.
- q_bar  output  WIDTH  bitwise complement of q.
- tc  output  1  combinational terminal count: en=1 and (up ? q==MODULUS-1 : q==0).
- wrap  output  1  registered one-cycle pulse: high the cycle after a wrap (or saturation hit, see option) was taken.

Behaviour:
- Reset: all state updates on rising clk only. reset=0 at an edge gives q=0, q_bar={WIDTH{1}}, wrap=0. Applies mid-count and overrides load/en.
- Priority per edge: reset > load > en > hold.
- Cell commands, encoded {J,K}: HOLD=00, CLR=01, SET=10, TGL=11. Every bit change happens through a cell command; no direct register writes to q.
- load=1: each bit gets SET if its target bit is 1, else CLR. Target is din, clamped to MODULUS-1 if din >= MODULUS. Load ignores en and up. wrap<=0.
- en=1, up=1, q != MODULUS-1: bit i gets TGL if all bits below i are 1, else HOLD. Bit 0 always TGL. Gives q+1. wrap<=0.
- en=1, up=1, q == MODULUS-1: every bit with q[i]=1 gets CLR, others HOLD. Next q=0. wrap<=1.
- en=1, up=0, q != 0: bit i gets TGL if all bits below i are 0, else HOLD. Gives q-1. wrap<=0.
- en=1, up=0, q == 0: bits get SET/CLR toward MODULUS-1. wrap<=1.
- en=0, load=0: all cells HOLD; q unchanged; wrap<=0.
- Latency: q reflects a command one clock after it is sampled.
- tc is combinational and asserts in the same cycle the wrap will be taken, for cascading en into the next stage.
- Direction change: takes effect on the same edge it is sampled; no state retained from the previous direction.
- Unreachable states q >= MODULUS (only possible via a forced X/reset glitch): up-count treats them as terminal (next=0); down-count decrements normally.

Optional Feature:
- Macro JK_CNT_SATURATE_EN.
- Defined: at q==MODULUS-1 with up=1, or q==0 with up=0, all cells HOLD (count sticks) and wrap pulses once per hold cycle; tc behaves as above.
- Undefined: modulo wrap as specified in Behaviour.

Decomposition:
- Package jk_cnt_pkg:
  - 2-bit enum jk_cmd_t (HOLD, CLR, SET, TGL).
  - Default WIDTH/MODULUS constants.
  - Function jk_cmd_for(cur_bit, next_bit) returning the minimal command.
- Sub-module jk_cell:
  - One JK storage bit with ports clk, reset (sync active-low), j, k, q, q_bar.
  - jk_mod_counter instantiates WIDTH copies with a generate loop.
  - Top level holds only excitation logic, clamp, tc and the wrap register.

Test Plan:
- Reset then en=1, up=1, 12 clocks, MODULUS=10: q goes 0..9, 0, 1; tc high exactly when q=9; wrap high the cycle q=0 follows 9.
- load=1, din=7, then up=0, en=1, 9 clocks: q goes 7..0, 9, 8; tc high at q=0; wrap pulse after 0->9.
- load=1, din=13 (>= MODULUS): q=9 next cycle. load=1 and en=1 together with din=3: q=3 (load wins).
- reset=0 asserted mid-count at q=6 with en=1, load=1: q=0, wrap=0 next edge. Holding reset low keeps q=0.
- en toggled 1,0,1 while counting up from 4: q goes 5, 5, 6. Toggle up mid-stream at q=5: q goes 4. q_bar == ~q every cycle.
- With JK_CNT_SATURATE_EN: count up from 8, 4 clocks: q goes 9, 9, 9, 9 with wrap high on each of the 3 held cycles. Without the macro, the same stimulus gives q = 9, 0, 1, 2.
